// File: rtl/user_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | user_pkg : register map, status/control bits, scan states, OBI types |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package user_pkg;

   localparam int unsigned OBI_AW = 32;
   localparam int unsigned OBI_DW = 32;

   typedef struct packed {
      logic              req;
      logic              we;
      logic [3:0]        be;
      logic [OBI_AW-1:0] addr;
      logic [OBI_DW-1:0] wdata;
   } sbr_obi_req_t;

   typedef struct packed {
      logic              valid;
      logic              err;
      logic [OBI_DW-1:0] rdata;
   } sbr_obi_r_t;

   typedef struct packed {
      logic       gnt;
      sbr_obi_r_t r;
   } sbr_obi_rsp_t;

   // Word index taken from address bits [4:2]
   localparam logic [2:0] REG_CTRL        = 3'd0;
   localparam logic [2:0] REG_STATUS      = 3'd1;
   localparam logic [2:0] REG_BASE        = 3'd2;
   localparam logic [2:0] REG_LEN         = 3'd3;
   localparam logic [2:0] REG_PATTERN     = 3'd4;
   localparam logic [2:0] REG_MASK        = 3'd5;
   localparam logic [2:0] REG_MATCH_COUNT = 3'd6;
   localparam logic [2:0] REG_FIRST_IDX   = 3'd7;

   // Register window; any set address bit in [REG_WINDOW_BITS-1:5] is an unmapped offset
   localparam int unsigned REG_WINDOW_BITS = 12;

   localparam int unsigned CTRL_START_BIT  = 0;
   localparam int unsigned CTRL_ABORT_BIT  = 1;
   localparam int unsigned CTRL_MODE_BIT   = 2;
   localparam int unsigned CTRL_IRQ_EN_BIT = 3;

   localparam int unsigned STATUS_BUSY_BIT    = 0;
   localparam int unsigned STATUS_DONE_BIT    = 1;
   localparam int unsigned STATUS_FOUND_BIT   = 2;
   localparam int unsigned STATUS_ABORTED_BIT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } scan_state_e;

   function automatic logic word_hit(input logic [OBI_DW-1:0] data,
                                     input logic [OBI_DW-1:0] pattern,
                                     input logic [OBI_DW-1:0] mask);
      return ((data ^ pattern) & mask) == '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/user_match_accel_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | user_match_accel_regs : OBI register slave, config and result CSRs  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module user_match_accel_regs
   import user_pkg::*;
#(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned CountWidth = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  sbr_obi_req_t          obi_req_i,
   output sbr_obi_rsp_t          obi_rsp_o,
   input  logic                  busy,
   input  logic                  clr_results,
   input  logic                  set_done,
   input  logic                  set_aborted,
   input  logic                  hit,
   input  logic [CountWidth-1:0] hit_idx,
   output logic                  start,
   output logic                  abort,
   output logic                  mode,
   output logic [AddrWidth-1:0]  base,
   output logic [CountWidth-1:0] len,
   output logic [DataWidth-1:0]  pattern,
   output logic [DataWidth-1:0]  mask,
   output logic                  irq
);

   logic                  ready_q;
   logic                  rsp_valid_q;
   logic                  rsp_err_q;
   logic [DataWidth-1:0]  rsp_rdata_q;
   logic                  irq_en;
   logic                  done;
   logic                  found;
   logic                  aborted;
   logic [CountWidth-1:0] match_count;
   logic [CountWidth-1:0] first_idx;

   logic                  gnt;
   logic                  addr_ok;
   logic                  wr;
   logic                  cfg_wr;
   logic                  w1c_done;
   logic                  w1c_aborted;
   logic [2:0]            word;
   logic [DataWidth-1:0]  wdata;
   logic [DataWidth-1:0]  rd_data;
   logic                  unused_bits;

   assign word        = obi_req_i.addr[4:2];
   assign addr_ok     = (obi_req_i.addr[REG_WINDOW_BITS-1:5] == '0);
   assign wdata       = obi_req_i.wdata;
   // ready_q keeps the slave silent in the first cycle out of reset
   assign gnt         = obi_req_i.req & ready_q & ~rsp_valid_q;
   assign wr          = gnt & obi_req_i.we & addr_ok;
   assign cfg_wr      = wr & ~busy;
   assign start       = wr & (word == REG_CTRL) & wdata[CTRL_START_BIT];
   assign abort       = wr & (word == REG_CTRL) & wdata[CTRL_ABORT_BIT];
   assign w1c_done    = wr & (word == REG_STATUS) & wdata[STATUS_DONE_BIT];
   assign w1c_aborted = wr & (word == REG_STATUS) & wdata[STATUS_ABORTED_BIT];
   assign irq         = done & irq_en;
   assign unused_bits = ^{obi_req_i.be, obi_req_i.addr[1:0],
                          obi_req_i.addr[OBI_AW-1:REG_WINDOW_BITS]};

   assign obi_rsp_o.gnt     = gnt;
   assign obi_rsp_o.r.valid = rsp_valid_q;
   assign obi_rsp_o.r.err   = rsp_err_q;
   assign obi_rsp_o.r.rdata = rsp_rdata_q;

   always_comb begin
      rd_data = '0;
      case (word)
         REG_CTRL: begin
            rd_data[CTRL_MODE_BIT]   = mode;
            rd_data[CTRL_IRQ_EN_BIT] = irq_en;
         end
         REG_STATUS: begin
            rd_data[STATUS_BUSY_BIT]    = busy;
            rd_data[STATUS_DONE_BIT]    = done;
            rd_data[STATUS_FOUND_BIT]   = found;
            rd_data[STATUS_ABORTED_BIT] = aborted;
         end
         REG_BASE:        rd_data = DataWidth'(base);
         REG_LEN:         rd_data = DataWidth'(len);
         REG_PATTERN:     rd_data = pattern;
         REG_MASK:        rd_data = mask;
         REG_MATCH_COUNT: rd_data = DataWidth'(match_count);
         REG_FIRST_IDX:   rd_data = DataWidth'(first_idx);
         default:         rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         ready_q     <= 1'b1;
         rsp_valid_q <= gnt;
         if (gnt) begin
            rsp_err_q   <= ~addr_ok;
            rsp_rdata_q <= (obi_req_i.we || !addr_ok) ? '0 : rd_data;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base    <= '0;
         len     <= '0;
         pattern <= '0;
         mask    <= '0;
         mode    <= 1'b0;
         irq_en  <= 1'b0;
      end else begin
         if (cfg_wr) begin
            case (word)
               REG_BASE:    base    <= wdata[AddrWidth-1:0];
               REG_LEN:     len     <= wdata[CountWidth-1:0];
               REG_PATTERN: pattern <= wdata;
               REG_MASK:    mask    <= wdata;
               REG_CTRL:    mode    <= wdata[CTRL_MODE_BIT];
               default:     ;
            endcase
         end
         // irq_en stays writable during a scan so software can mask the interrupt
         if (wr && (word == REG_CTRL)) begin
            irq_en <= wdata[CTRL_IRQ_EN_BIT];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         done        <= 1'b0;
         aborted     <= 1'b0;
         found       <= 1'b0;
         match_count <= '0;
         first_idx   <= '1;
      end else begin
         if (set_done) begin
            done <= 1'b1;
         end else if (clr_results || w1c_done) begin
            done <= 1'b0;
         end
         if (set_aborted) begin
            aborted <= 1'b1;
         end else if (clr_results || w1c_aborted) begin
            aborted <= 1'b0;
         end
         if (clr_results) begin
            found       <= 1'b0;
            match_count <= '0;
            first_idx   <= '1;
         end else if (hit) begin
            found <= 1'b1;
            if (!found) begin
               first_idx <= hit_idx;
            end
            if (match_count != '1) begin
               match_count <= match_count + CountWidth'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/user_match_accel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | user_match_accel : memory pattern-match scanner with OBI CSR access |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module user_match_accel
   import user_pkg::*;
#(
   parameter int unsigned DataWidth  = 32,
   parameter int unsigned AddrWidth  = 32,
   parameter int unsigned CountWidth = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  sbr_obi_req_t         obi_req_i,
   output sbr_obi_rsp_t         obi_rsp_o,
   output logic                 mem_req_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic                 irq_o
);

   scan_state_e           state;
   logic [CountWidth-1:0] idx;
   logic [AddrWidth-1:0]  addr;
   logic                  abort_pend;

   logic                  start;
   logic                  abort;
   logic                  mode;
   logic [AddrWidth-1:0]  base;
   logic [CountWidth-1:0] len;
   logic [DataWidth-1:0]  pattern;
   logic [DataWidth-1:0]  mask;
   logic                  busy;
   logic                  clr_results;
   logic                  set_done;
   logic                  set_aborted;
   logic                  hit;
   logic                  word_match;
   logic                  last_word;

   user_match_accel_regs #(
      .DataWidth  (DataWidth),
      .AddrWidth  (AddrWidth),
      .CountWidth (CountWidth)
   ) u_regs (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .obi_req_i   (obi_req_i),
      .obi_rsp_o   (obi_rsp_o),
      .busy        (busy),
      .clr_results (clr_results),
      .set_done    (set_done),
      .set_aborted (set_aborted),
      .hit         (hit),
      .hit_idx     (idx),
      .start       (start),
      .abort       (abort),
      .mode        (mode),
      .base        (base),
      .len         (len),
      .pattern     (pattern),
      .mask        (mask),
      .irq         (irq_o)
   );

   assign busy       = (state != ST_IDLE);
   assign mem_req_o  = (state == ST_REQ);
   assign mem_addr_o = addr;
   assign word_match = word_hit(mem_rdata_i, pattern, mask);
   assign last_word  = (idx == len - CountWidth'(1));

   always_comb begin
      clr_results = 1'b0;
      set_done    = 1'b0;
      set_aborted = 1'b0;
      hit         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               clr_results = 1'b1;
               set_done    = (len == '0);
            end
         end
         ST_REQ: begin
            if (abort && !mem_gnt_i) begin
               set_done    = 1'b1;
               set_aborted = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_rvalid_i) begin
               if (abort_pend || abort) begin
                  set_done    = 1'b1;
                  set_aborted = 1'b1;
               end else begin
                  hit      = word_match;
                  set_done = last_word || (!mode && word_match);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         idx        <= '0;
         addr       <= '0;
         abort_pend <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && (len != '0)) begin
                  idx        <= '0;
                  addr       <= base;
                  abort_pend <= 1'b0;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A grant in the abort cycle still owes us a response; drain it in WAIT
               if (mem_gnt_i) begin
                  abort_pend <= abort;
                  state      <= ST_WAIT;
               end else if (abort) begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (mem_rvalid_i) begin
                  if (set_done) begin
                     state <= ST_IDLE;
                  end else begin
                     idx   <= idx + CountWidth'(1);
                     addr  <= addr + AddrWidth'(4);
                     state <= ST_REQ;
                  end
               end else if (abort) begin
                  abort_pend <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/user_match_accel.md
USER_MATCH_ACCEL -- requirements
Module: user_match_accel

Interface
REQ-001 SHALL have parameter DataWidth, 32, memory word and pattern width (32 only).
REQ-002 SHALL have parameter AddrWidth, 32, memory address width.
REQ-003 SHALL have parameter CountWidth, 16, width of LEN, MATCH_COUNT and FIRST_IDX.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port obi_req_i  input  sbr_obi_req_t  register-access OBI subordinate request.
REQ-007 SHALL have port obi_rsp_o  output  sbr_obi_rsp_t  OBI subordinate response (gnt, r.valid, r.rdata, r.err).
REQ-008 SHALL have port mem_req_o  output  1  memory read request.
REQ-009 SHALL have port mem_addr_o  output  AddrWidth  byte address of the word being read.
REQ-010 SHALL have port mem_gnt_i  input  1  memory accepts request.
REQ-011 SHALL have port mem_rvalid_i  input  1  read data valid.
REQ-012 SHALL have port mem_rdata_i  input  DataWidth  read data.
REQ-013 SHALL have port irq_o  output  1  level interrupt = STATUS.done & CTRL.irq_en.

Function
REQ-014 Register map, word offsets: 0x00 CTRL, 0x04 STATUS, 0x08 BASE, 0x0C LEN, 0x10 PATTERN, 0x14 MASK, 0x18 MATCH_COUNT (RO), 0x1C FIRST_IDX (RO); address bits [4:2] decode; other offsets -> r.err=1, rdata 0, no side effect.
REQ-015 CTRL: bit0 start (W1, reads 0), bit1 abort (W1, reads 0), bit2 mode (0 stop-at-first, 1 count-all), bit3 irq_en; STATUS: bit0 busy, bit1 done (W1C), bit2 found, bit3 aborted (W1C).
REQ-016 OBI: gnt = obi_req_i.req when no response is pending; r.valid asserted exactly one cycle after grant for one cycle; write responses return rdata 0; be ignored (full-word access).
REQ-017 Writes to BASE, LEN, PATTERN, MASK, mode while busy SHALL be ignored (err=0).
REQ-018 FSM states IDLE, REQ, WAIT; start in IDLE clears MATCH_COUNT, found, done, aborted, sets FIRST_IDX all-ones, index i=0, goes REQ (LEN=0: go straight to done in IDLE next cycle, busy never set beyond that cycle).
REQ-019 REQ: mem_req_o=1, mem_addr_o = BASE + 4*i modulo 2^AddrWidth (wrap, no error); on mem_gnt_i -> WAIT; address stable while ungranted.
REQ-020 WAIT: on mem_rvalid_i, hit = ((mem_rdata_i ^ PATTERN) & MASK) == 0; hit increments MATCH_COUNT (saturating at 2^CountWidth-1) and, if first hit, latches FIRST_IDX=i and sets found.
REQ-021 After a WAIT word: if i==LEN-1, or mode=0 and hit, -> IDLE with done=1; else i+=1, -> REQ.
REQ-022 At most one outstanding memory read; mem_rvalid_i outside WAIT ignored.
REQ-023 Start while busy ignored; abort in IDLE ignored; abort in REQ before grant -> IDLE next cycle; abort in WAIT -> IDLE after the pending rvalid (data discarded); abort sets done=1 and aborted=1.
REQ-024 Start and abort in same write: abort wins if busy, start wins if idle.
REQ-025 busy = (state != IDLE); done set and W1C clear in same cycle: set wins.

Reset
REQ-026 On rst_ni low, asynchronously: state IDLE, all registers 0 except FIRST_IDX all-ones; mem_req_o=0, irq_o=0, obi_rsp_o all-zero.
REQ-027 Reset mid-scan SHALL abandon outstanding reads; no response is owed after reset release.

Structure
REQ-028 Register offsets, CTRL/STATUS bit indices and the state enum SHALL live in user_pkg.
REQ-029 OBI decode/CSR storage SHALL be sub-module user_match_accel_regs; scan FSM stays in top.

Verification
REQ-030 BASE=0x1000_0000, LEN=4, PATTERN=0xCAFE, MASK=0xFFFF, mode=1, words {0x1CAFE,0,0xCAFE,5} -> MATCH_COUNT=2, FIRST_IDX=0, found=1, done=1, 4 reads at +0,+4,+8,+0xC.
REQ-031 Same data, mode=0 -> exactly 1 read issued, FIRST_IDX=0, irq_o=1 when irq_en=1; W1C done -> irq_o=0.
REQ-032 LEN=0, start -> done=1 one cycle later, no mem_req_o, FIRST_IDX=0xFFFF.
REQ-033 BASE=0xFFFF_FFF8, LEN=3 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-034 mem_gnt_i held low 5 cycles then abort in WAIT with rvalid 3 cycles later -> IDLE after rvalid, aborted=1, count unchanged by discarded word.
REQ-035 Read offset 0x20 -> r.err=1, rdata 0; write LEN while busy -> LEN unchanged.
